// File: rtl/dut_arb_pkg.sv
// -----------------------------------------------------------------------------
// dut_arb_pkg
// Shared definitions for the request arbiter in front of a single DUT port:
//   - arb_state_e : arbiter FSM state (IDLE / BUSY)
//   - DEF_*       : default values for the NUM_REQ, DATA_W and TIMEOUT parameters
//   - idx_width() : width of an index into a vector of n requesters (min 1)
// -----------------------------------------------------------------------------
package dut_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // $clog2(1) is 0, which would give zero-width index vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin search. Starting at ptr_i and walking
// upwards with wrap-around, returns the first asserted request.
//   req_i    in  NUM_REQ  request vector
//   ptr_i    in  IDX_W    index with highest priority this round
//   found_o  out 1        at least one request is asserted
//   winner_o out IDX_W    index of the selected request (0 when none)
// -----------------------------------------------------------------------------
module rr_picker
  import dut_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   winner_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;

  // Scan offsets from the far end down to 0 so the candidate closest to
  // ptr_i is the last one written and therefore wins.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    cand     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_i} + CW'(i);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (req_i[cand[IDX_W-1:0]]) begin
        found_o  = 1'b1;
        winner_o = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dut_req_arbiter.sv
// -----------------------------------------------------------------------------
// dut_req_arbiter
// Shares one DUT port between NUM_REQ requesters with round-robin fairness and
// a per-transaction watchdog.
//
// Handshake: a requester raises req_valid_i[k] with req_data_i[k] stable and
// keeps both until it sees a one-cycle req_ack_o[k] (completed) or
// req_err_o[k] (aborted by the watchdog). Towards the DUT, dut_valid_o is high
// for the whole grant with dut_data_o frozen; the DUT finishes the transfer by
// asserting dut_ack_i for one cycle, which is forwarded combinationally to the
// granted requester. dut_ack_i is ignored while no grant is active.
//
// Ports:
//   clk_i        in  1               clock, rising edge
//   rstn_i       in  1               asynchronous active-low reset
//   req_valid_i  in  NUM_REQ         per-requester request
//   req_data_i   in  NUM_REQ*DATA_W  payloads, requester k at [k*DATA_W +: DATA_W]
//   req_ack_o    out NUM_REQ         completion pulse to the granted requester
//   req_err_o    out NUM_REQ         timeout-abort pulse to the granted requester
//   dut_valid_o  out 1               valid towards the DUT (registered)
//   dut_data_o   out DATA_W          latched payload towards the DUT
//   dut_ack_i    in  1               ack from the DUT
//   busy_o       out 1               a grant is active
//   grant_id_o   out IDX_W           current or most recent grant index
// -----------------------------------------------------------------------------
module dut_req_arbiter
  import dut_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ack_o,
  output logic [NUM_REQ-1:0]        req_err_o,
  output logic                      dut_valid_o,
  output logic [DATA_W-1:0]         dut_data_o,
  input  logic                      dut_ack_i,
  output logic                      busy_o,
  output logic [IDX_W-1:0]          grant_id_o
);

  localparam int WD_W = $clog2(TIMEOUT);

  // FSM state, kept as a named enum so checkers can bind to it directly.
  arb_state_e        state_q;
  arb_state_e        state_d;

  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  grant_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [WD_W-1:0]   wdog_q;

  logic              found;
  logic [IDX_W-1:0]  winner;
  logic              in_busy;
  logic              ack_hit;
  logic              tmo_hit;
  logic [IDX_W-1:0]  grant_next;

  logic [DATA_W-1:0] req_data_a [NUM_REQ];

  // Flat payload bus viewed as one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data_a[i] = req_data_i[i*DATA_W +: DATA_W];
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .found_o  (found),
    .winner_o (winner)
  );

  // Ack takes priority over the watchdog when both land in the same cycle.
  assign in_busy = (state_q == ST_BUSY);
  assign ack_hit = in_busy && dut_ack_i;
  assign tmo_hit = in_busy && !dut_ack_i && (wdog_q == WD_W'(TIMEOUT - 1));

  // Requester following the one just served gets first look next round.
  assign grant_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. Leaving BUSY always passes through IDLE, which
  // guarantees the one-cycle gap with dut_valid_o low between grants.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ack_hit || tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The per-requester pulses are decoded from the registered
  // grant index, so they are zero whenever the FSM is (or is reset to) IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ack_o = '0;
    req_err_o = '0;
    if (ack_hit) begin
      req_ack_o[grant_q] = 1'b1;
    end
    if (tmo_hit) begin
      req_err_o[grant_q] = 1'b1;
    end
    busy_o = in_busy;
  end

  // ---------------------------------------------------------------------------
  // Grant datapath: grant index, payload latch, DUT valid, watchdog, pointer.
  // The payload is captured once on BUSY entry; requesters may change or drop
  // their inputs during the grant without affecting the DUT side.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      wdog_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            grant_q <= winner;
            data_q  <= req_data_a[winner];
            valid_q <= 1'b1;
            wdog_q  <= '0;
          end
        end
        ST_BUSY: begin
          if (ack_hit || tmo_hit) begin
            valid_q  <= 1'b0;
            rr_ptr_q <= grant_next;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign dut_valid_o = valid_q;
  assign dut_data_o  = data_q;
  assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_dut_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dut_req_arbiter
// Directed bench for dut_req_arbiter (NUM_REQ=4, DATA_W=32, TIMEOUT=8).
// Inputs are driven 2 time units after the rising edge; outputs are checked a
// further unit later, well before the next edge.
// -----------------------------------------------------------------------------
module tb_dut_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic                      clk_i = 1'b0;
  logic                      rstn_i = 1'b0;
  logic [NUM_REQ-1:0]        req_valid_i = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data_i = '0;
  logic [NUM_REQ-1:0]        req_ack_o;
  logic [NUM_REQ-1:0]        req_err_o;
  logic                      dut_valid_o;
  logic [DATA_W-1:0]         dut_data_o;
  logic                      dut_ack_i = 1'b0;
  logic                      busy_o;
  logic [1:0]                grant_id_o;

  always #5 clk_i = ~clk_i;

  dut_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ack_o   (req_ack_o),
    .req_err_o   (req_err_o),
    .dut_valid_o (dut_valid_o),
    .dut_data_o  (dut_data_o),
    .dut_ack_i   (dut_ack_i),
    .busy_o      (busy_o),
    .grant_id_o  (grant_id_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic nxt();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_data(input int k, input logic [DATA_W-1:0] val);
    req_data_i[k*DATA_W +: DATA_W] = val;
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int k);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Called at a drive point of an IDLE cycle with requests already set.
  // Checks the grant, acks in BUSY cycle ack_cyc, and ends at the drive point
  // of the following IDLE cycle after checking the gap.
  task automatic run_txn(input string tag, input int exp_g, input logic [DATA_W-1:0] exp_d,
                         input int ack_cyc);
    nxt();
    #1;
    check_val({tag, ".valid"}, 64'(dut_valid_o), 64'd1);
    check_val({tag, ".grant"}, 64'(grant_id_o), 64'(exp_g));
    check_val({tag, ".data"},  64'(dut_data_o), 64'(exp_d));
    for (int c = 1; c < ack_cyc; c++) begin
      check_val({tag, ".noack"}, 64'(req_ack_o), 64'd0);
      nxt();
    end
    dut_ack_i = 1'b1;
    #1;
    check_val({tag, ".ack"}, 64'(req_ack_o), 64'(onehot(exp_g)));
    check_val({tag, ".err"}, 64'(req_err_o), 64'd0);
    nxt();
    dut_ack_i = 1'b0;
    #1;
    check_val({tag, ".gap_valid"}, 64'(dut_valid_o), 64'd0);
    check_val({tag, ".gap_busy"},  64'(busy_o), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < NUM_REQ; k++) set_data(k, 32'hA000_0000 | 32'(k));

    // Reset state, with all requesters already asserting.
    req_valid_i = 4'hF;
    nxt();
    nxt();
    check_val("rst.valid", 64'(dut_valid_o), 64'd0);
    check_val("rst.data",  64'(dut_data_o), 64'd0);
    check_val("rst.busy",  64'(busy_o), 64'd0);
    check_val("rst.grant", 64'(grant_id_o), 64'd0);
    check_val("rst.ack",   64'(req_ack_o), 64'd0);
    check_val("rst.err",   64'(req_err_o), 64'd0);
    rstn_i = 1'b1;

    // All four held high: fair rotation 0,1,2,3,0 with an IDLE gap each time.
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    while (exp_q.size() > 0) begin
      logic [1:0] g;
      g = exp_q.pop_front();
      run_txn("rot", int'(g), 32'hA000_0000 | 32'(g), 1);
    end
    req_valid_i = '0;

    // Single request, DUT acks after one valid cycle.
    set_data(2, 32'hCAFE_0002);
    req_valid_i = 4'b0100;
    run_txn("single", 2, 32'hCAFE_0002, 2);
    req_valid_i = '0;
    check_val("single.ptr", 64'(dut.rr_ptr_q), 64'd3);

    // Pointer at 3: 1010 must pick 3, then the pointer wraps to 0.
    req_valid_i = 4'b1010;
    run_txn("ptr3", 3, 32'hA000_0003, 1);
    req_valid_i = '0;
    check_val("wrap.ptr", 64'(dut.rr_ptr_q), 64'd0);
    req_valid_i = 4'b0011;
    run_txn("wrap", 0, 32'hA000_0000, 1);
    req_valid_i = '0;

    // Ack while IDLE is ignored.
    dut_ack_i = 1'b1;
    #1;
    check_val("idleack.ack", 64'(req_ack_o), 64'd0);
    nxt();
    check_val("idleack.busy", 64'(busy_o), 64'd0);
    dut_ack_i = 1'b0;

    // Timeout: requester 1 granted, DUT silent, err in the 8th BUSY cycle.
    req_valid_i = 4'b0010;
    nxt();
    for (int c = 1; c <= TIMEOUT; c++) begin
      #1;
      check_val("tmo.busy", 64'(busy_o), 64'd1);
      check_val("tmo.err", 64'(req_err_o), (c == TIMEOUT) ? 64'h2 : 64'h0);
      nxt();
    end
    #1;
    check_val("tmo.idle", 64'(busy_o), 64'd0);
    check_val("tmo.err_clr", 64'(req_err_o), 64'd0);
    req_valid_i = 4'b0110;
    run_txn("tmo.next", 2, 32'hCAFE_0002, 1);
    req_valid_i = '0;

    // Ack lands on the watchdog expiry cycle: ack wins, no err.
    req_valid_i = 4'b1000;
    nxt();
    for (int c = 1; c < TIMEOUT; c++) nxt();
    dut_ack_i = 1'b1;
    #1;
    check_val("race.ack", 64'(req_ack_o), 64'h8);
    check_val("race.err", 64'(req_err_o), 64'h0);
    nxt();
    dut_ack_i = 1'b0;
    req_valid_i = '0;
    #1;
    check_val("race.idle", 64'(busy_o), 64'd0);
    check_val("race.err_clr", 64'(req_err_o), 64'h0);

    // Granted requester drops valid and changes data mid-BUSY.
    set_data(0, 32'h1234_5678);
    req_valid_i = 4'b0001;
    nxt();
    #1;
    check_val("drop.grant", 64'(grant_id_o), 64'd0);
    req_valid_i = '0;
    set_data(0, 32'hDEAD_BEEF);
    nxt();
    #1;
    check_val("drop.busy", 64'(busy_o), 64'd1);
    check_val("drop.data", 64'(dut_data_o), 64'h1234_5678);
    nxt();
    dut_ack_i = 1'b1;
    #1;
    check_val("drop.ack", 64'(req_ack_o), 64'h1);
    check_val("drop.data2", 64'(dut_data_o), 64'h1234_5678);
    nxt();
    dut_ack_i = 1'b0;
    #1;
    check_val("drop.idle", 64'(busy_o), 64'd0);

    // Reset in the middle of BUSY.
    set_data(0, 32'hA000_0000);
    req_valid_i = 4'b0100;
    nxt();
    nxt();
    #1;
    check_val("rstbusy.pre", 64'(busy_o), 64'd1);
    rstn_i = 1'b0;
    dut_ack_i = 1'b1;
    #1;
    check_val("rstbusy.valid", 64'(dut_valid_o), 64'd0);
    check_val("rstbusy.data",  64'(dut_data_o), 64'd0);
    check_val("rstbusy.busy",  64'(busy_o), 64'd0);
    check_val("rstbusy.grant", 64'(grant_id_o), 64'd0);
    check_val("rstbusy.ack",   64'(req_ack_o), 64'd0);
    check_val("rstbusy.err",   64'(req_err_o), 64'd0);
    dut_ack_i = 1'b0;
    req_valid_i = 4'hF;
    nxt();
    #1;
    check_val("rstbusy.hold", 64'(busy_o), 64'd0);
    rstn_i = 1'b1;
    run_txn("rstbusy.first", 0, 32'hA000_0000, 1);
    req_valid_i = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
